// File: rtl/i_fetch_pkg.sv
// Shared widths, constants and the fetch queue entry type for the i_fetch stage.
package i_fetch_pkg;

  localparam int          WORD_W    = 64;
  localparam int          INSTR_W   = 32;
  localparam logic [63:0] PC_STEP   = 64'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // One buffered fetch result: the word and the PC it was read from.
  typedef struct packed {
    logic [WORD_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry circular buffer of {pc, instruction} with push, pop and flush.
// Flush wins over push and pop in the same cycle.
module fetch_queue
  import i_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wptr;
  logic         rptr;

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push && !flush) begin
      mem[wptr] <= din;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle-latency reads
// to instruction memory, buffers returned words in a 2-entry queue and
// presents {instruction, cur_pc_out} to decode under valid/ready.
// Build option IFETCH_PERF_EN adds perf_fetched / perf_stalls counters.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_taken,
  input  logic [WORD_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [WORD_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [WORD_W-1:0]  cur_pc_out
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls
`endif
);

  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] pc_tag;
  logic              inflight;
  logic [1:0]        count;
  logic              pop;
  logic              push;
  logic [2:0]        occupancy;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;

  // Words held plus the one in flight, after this cycle's pop, must leave
  // room for the word we are about to request. Held low while in reset.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign imem_req  = rst_n && !branch_taken && (occupancy < 3'(QUEUE_DEPTH));
  assign imem_addr = fetch_pc;

  // A response arriving in a branch cycle is wrong-path and is dropped.
  assign push       = inflight && !branch_taken;
  assign push_entry = '{pc: pc_tag, instr: imem_data};

  assign instruction = instr_valid ? head.instr : NOP_INSTR;
  assign cur_pc_out  = instr_valid ? head.pc    : '0;

  // Fetch PC, in-flight flag and the PC tag of the outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      pc_tag   <= '0;
      inflight <= 1'b0;
    end else if (branch_taken) begin
      fetch_pc <= align_pc(branch_target);
      inflight <= 1'b0;
    end else if (imem_req) begin
      fetch_pc <= fetch_pc + PC_STEP;
      pc_tag   <= fetch_pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

`ifdef IFETCH_PERF_EN
  // Accepted-instruction and decode-backpressure counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stalls  <= 32'd0;
    end else begin
      if (pop)                         perf_fetched <= perf_fetched + 32'd1;
      if (instr_valid && !instr_ready) perf_stalls  <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i_fetch.sv
// Self-checking bench for i_fetch: directed latency/stall/branch/reset
// scenarios followed by randomized ready, branch and reset traffic.
module tb_i_fetch;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] cur_pc_out;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  int total = 0;
  int bad   = 0;

  i_fetch #(.RESET_PC(RST_PC), .QUEUE_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .cur_pc_out    (cur_pc_out)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    w = a >> 2;
    return (w[31:0] * 32'h9E3779B1) ^ w[63:32] ^ 32'h5A5A1234;
  endfunction

  // Synchronous instruction memory; returns garbage when not read.
  always @(posedge clk) begin
    if (imem_req) imem_data <= mem_word(imem_addr);
    else          imem_data <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model and per-cycle compare ----------------
  logic [63:0] exp_pc;
  int          idle;
  logic        stalled_prev;
  logic [63:0] prev_pc;
  logic [31:0] prev_instr;
  logic [31:0] m_pops;
  logic [31:0] m_stalls;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc       = RST_PC;
      idle         = 0;
      stalled_prev = 1'b0;
      m_pops       = 0;
      m_stalls     = 0;
      chk("rst_valid", {63'd0, instr_valid}, 64'd0);
      chk("rst_req", {63'd0, imem_req}, 64'd0);
    end else begin
`ifdef IFETCH_PERF_EN
      chk("perf_fetched", {32'd0, perf_fetched}, {32'd0, m_pops});
      chk("perf_stalls", {32'd0, perf_stalls}, {32'd0, m_stalls});
`endif
      if (stalled_prev) begin
        chk("hold_valid", {63'd0, instr_valid}, 64'd1);
        chk("hold_pc", cur_pc_out, prev_pc);
        chk("hold_instr", {32'd0, instruction}, {32'd0, prev_instr});
      end
      if (instr_valid) idle = 0;
      else             idle++;
      chk("liveness", {63'd0, idle > 2}, 64'd0);
      if (instr_valid && instr_ready) begin
        chk("pop_pc", cur_pc_out, exp_pc);
        chk("pop_instr", {32'd0, instruction}, {32'd0, mem_word(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        m_pops = m_pops + 32'd1;
      end
      if (instr_valid && !instr_ready) m_stalls = m_stalls + 32'd1;
      if (branch_taken) begin
        chk("branch_req", {63'd0, imem_req}, 64'd0);
        exp_pc = {branch_target[63:2], 2'b00};
        idle   = 0;
      end
      stalled_prev = instr_valid && !instr_ready && !branch_taken;
      prev_pc      = cur_pc_out;
      prev_instr   = instruction;
    end
  end

  // Release reset and check the C0 request and C2 first-valid timing.
  task automatic release_and_start(input string tag);
    rst_n = 1'b1;
    #1;
    chk({tag, "_c0_req"}, {63'd0, imem_req}, 64'd1);
    chk({tag, "_c0_addr"}, imem_addr, RST_PC);
    tick();
    chk({tag, "_c1_valid"}, {63'd0, instr_valid}, 64'd0);
    tick();
    chk({tag, "_c2_valid"}, {63'd0, instr_valid}, 64'd1);
    chk({tag, "_c2_pc"}, cur_pc_out, RST_PC);
    chk({tag, "_c2_instr"}, {32'd0, instruction}, {32'd0, mem_word(RST_PC)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    instr_ready   = 1'b1;
    repeat (3) tick();
    chk("reset_instr", {32'd0, instruction}, 64'd0);
    chk("reset_pc", cur_pc_out, 64'd0);
`ifdef IFETCH_PERF_EN
    chk("reset_perf_f", {32'd0, perf_fetched}, 64'd0);
    chk("reset_perf_s", {32'd0, perf_stalls}, 64'd0);
`endif

    // Streaming start-up.
    release_and_start("start");
    tick(); chk("seq_pc4", cur_pc_out, 64'd4);
    tick(); chk("seq_pc8", cur_pc_out, 64'd8);
    tick(); chk("seq_pc12", cur_pc_out, 64'd12);
    chk("seq_instr12", {32'd0, instruction}, {32'd0, mem_word(64'd12)});

    // Mid-stream reset drops everything at once; then a held-off decode.
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
    instr_ready = 1'b0;
    tick();
    release_and_start("restart");
    repeat (4) tick();
    chk("stall_req", {63'd0, imem_req}, 64'd0);
    chk("stall_head", cur_pc_out, 64'd0);
    instr_ready = 1'b1;
    tick();
    chk("unstall_pc", cur_pc_out, 64'd4);
    repeat (2) tick();

    // Branch with nothing popped in the branch cycle.
    instr_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 64'h100;
    #1;
    chk("br_req_b", {63'd0, imem_req}, 64'd0);
    tick();
    branch_taken = 1'b0;
    instr_ready  = 1'b1;
    #1;
    chk("br_b1_valid", {63'd0, instr_valid}, 64'd0);
    chk("br_b1_req", {63'd0, imem_req}, 64'd1);
    chk("br_b1_addr", imem_addr, 64'h100);
    tick();
    chk("br_b2_valid", {63'd0, instr_valid}, 64'd0);
    tick();
    chk("br_b3_valid", {63'd0, instr_valid}, 64'd1);
    chk("br_b3_pc", cur_pc_out, 64'h100);
    repeat (2) tick();

    // Branch coinciding with a pop; misaligned target.
    chk("brpop_valid", {63'd0, instr_valid}, 64'd1);
    branch_taken  = 1'b1;
    branch_target = 64'h203;
    tick();
    branch_taken = 1'b0;
    repeat (2) tick();
    chk("brpop_pc", cur_pc_out, 64'h200);
    chk("brpop_valid2", {63'd0, instr_valid}, 64'd1);
    tick();

`ifdef IFETCH_PERF_EN
    // 10 pops and 3 stall cycles from a clean reset.
    rst_n = 1'b0;
    tick();
    release_and_start("perf");
    repeat (7) tick();
    instr_ready = 1'b0;
    repeat (3) tick();
    instr_ready = 1'b1;
    repeat (3) tick();
    chk("perf_ten", {32'd0, perf_fetched}, 64'd10);
    chk("perf_three", {32'd0, perf_stalls}, 64'd3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
      end
      instr_ready  = ($urandom_range(9) < 7);
      branch_taken = ($urandom_range(19) == 0);
      case ($urandom_range(3))
        0:       branch_target = 64'hFFFF_FFFF_FFFF_FFF4 + 64'($urandom_range(3));
        1:       branch_target = 64'($urandom_range(255));
        default: branch_target = {$urandom, $urandom};
      endcase
      tick();
    end

    rst_n        = 1'b1;
    branch_taken = 1'b0;
    instr_ready  = 1'b1;
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
